// File: rtl/dsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsm_pkg
// Description : Shared constants and types for the delta-sigma bitstream
//               generator and its matching decimator. Holds the accumulator
//               guard-bit count, the accumulator width derivation, the
//               saturation limits, the accumulator type and the dither seed.
// Revision    : 1.0  initial release
// ============================================================================
package dsm_pkg;

    // Headroom above the sample width so the integrators can swing well past
    // full scale before clamping.
    localparam int C_GUARD_BITS    = 4;

    // Reference sample width; the decimator sizes its datapath from this.
    localparam int C_DEFAULT_DATA_W = 12;

    // Accumulator width for a given sample width.
    function automatic int acc_width(input int data_w);
        return data_w + C_GUARD_BITS;
    endfunction

    // Symmetric saturation magnitude for a given accumulator width.
    function automatic int sat_limit(input int acc_w);
        return (2 ** (acc_w - 1)) - 1;
    endfunction

    localparam int C_ACC_W   = C_DEFAULT_DATA_W + C_GUARD_BITS;
    localparam int C_ACC_MAX = (2 ** (C_ACC_W - 1)) - 1;
    localparam int C_ACC_MIN = -C_ACC_MAX;

    typedef logic signed [C_ACC_W-1:0] acc_t;

    // Non-zero start state for the dither LFSR.
    localparam logic [15:0] C_LFSR_SEED = 16'hACE1;

endpackage : dsm_pkg
`default_nettype wire

// File: rtl/dsm_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : dsm_lfsr
// Description : 16-bit maximal-length Fibonacci LFSR used as a one-bit dither
//               source. Polynomial x^16 + x^14 + x^13 + x^11 + 1, shifting
//               right one position every clock.
// Ports       : clk   - clock
//               rstN  - asynchronous active-low reset, loads SEED
//               state - current register contents (bit 0 is the dither bit)
// Revision    : 1.0  initial release
// ============================================================================
module dsm_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rstN,
    output logic [15:0] state
);

    logic [15:0] r_state;
    logic        w_feedback;

    // Taps 16/14/13/11 map to bits 0/2/3/5 of a right-shifting register.
    assign w_feedback = r_state[0] ^ r_state[2] ^ r_state[3] ^ r_state[5];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= SEED;
        end else begin
            r_state <= {w_feedback, r_state[15:1]};
        end
    end

    assign state = r_state;

endmodule : dsm_lfsr
`default_nettype wire

// File: rtl/dsm_bitstream_gen.sv
`default_nettype none
// ============================================================================
// Module      : dsm_bitstream_gen
// Description : Second-order digital delta-sigma modulator. Converts signed
//               PCM samples into a 1-bit bitstream at the clock rate. A
//               free-running frame counter defines the sample period; samples
//               enter through a one-deep pending buffer and are promoted to
//               the active register at each frame boundary.
// Ports       : clk          - modulator clock, one output bit per cycle
//               rstN         - asynchronous active-low reset
//               sampleIn     - signed PCM sample (DATA_W bits)
//               sampleValid  - sampleIn valid
//               sampleReady  - pending buffer free (valid & ready = transfer)
//               bitOut       - registered modulator output, 1 = +FS
//               frameStrobe  - one-cycle pulse when the active sample updates
//               underrun     - one-cycle pulse when a boundary found no sample
// Options     : DSM_DITHER_EN - when defined, a 16-bit LFSR adds +/-1 LSB of
//               dither into the second integrator to break idle tones.
// Revision    : 1.0  initial release
// ============================================================================
module dsm_bitstream_gen
    import dsm_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int OSR_LOG2 = 6
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [DATA_W-1:0] sampleIn,
    input  logic              sampleValid,
    output logic              sampleReady,
    output logic              bitOut,
    output logic              frameStrobe,
    output logic              underrun
);

    // Accumulator width plus two extra bits so that a sum of three
    // accumulator-sized terms can be range-checked before clamping.
    localparam int C_AW  = acc_width(DATA_W);
    localparam int C_EW  = C_AW + 2;
    localparam int C_LIM = sat_limit(C_AW);

    localparam logic signed [C_EW-1:0] C_FS     = C_EW'(2 ** (DATA_W - 1));
    localparam logic signed [C_EW-1:0] C_SAT_HI = C_EW'(C_LIM);
    localparam logic signed [C_EW-1:0] C_SAT_LO = -C_SAT_HI;
    localparam logic [OSR_LOG2-1:0]    C_CNT_MAX = '1;

    // Clamp an extended sum back into accumulator range.
    function automatic logic signed [C_AW-1:0] sat(input logic signed [C_EW-1:0] v);
        logic signed [C_EW-1:0] t;
        if (v > C_SAT_HI) begin
            t = C_SAT_HI;
        end else if (v < C_SAT_LO) begin
            t = C_SAT_LO;
        end else begin
            t = v;
        end
        return t[C_AW-1:0];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [OSR_LOG2-1:0]      r_cnt;
    logic signed [DATA_W-1:0] r_active;
    logic [DATA_W-1:0]        r_pending;
    logic                     r_pend_full;
    logic signed [C_AW-1:0]   r_acc1;
    logic signed [C_AW-1:0]   r_acc2;
    logic                     r_bit;
    logic                     r_strobe;
    logic                     r_under;

    logic                     w_boundary;
    logic                     w_xfer;
    logic signed [C_EW-1:0]   w_fb;
    logic signed [C_EW-1:0]   w_sum1;
    logic signed [C_EW-1:0]   w_sum2;
    logic signed [C_AW-1:0]   w_acc1_nxt;
    logic signed [C_AW-1:0]   w_acc2_nxt;
    logic signed [C_EW-1:0]   w_dith;

    // ------------------------------------------------------------------
    // Dither source
    // ------------------------------------------------------------------
`ifdef DSM_DITHER_EN
    localparam logic signed [C_EW-1:0] C_ONE = C_EW'(1);
    logic [15:0] w_lfsr;

    dsm_lfsr #(
        .SEED  (C_LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rstN  (rstN),
        .state (w_lfsr)
    );

    assign w_dith = w_lfsr[0] ? C_ONE : -C_ONE;
`else
    assign w_dith = '0;
`endif

    // ------------------------------------------------------------------
    // Handshake and frame timing
    // ------------------------------------------------------------------
    assign w_boundary  = (r_cnt == C_CNT_MAX);
    assign w_xfer      = sampleValid && !r_pend_full;
    assign sampleReady = !r_pend_full;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_cnt       <= '0;
            r_active    <= '0;
            r_pending   <= '0;
            r_pend_full <= 1'b0;
            r_strobe    <= 1'b0;
            r_under     <= 1'b0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
            r_strobe <= w_boundary;
            r_under  <= 1'b0;
            if (w_boundary) begin
                if (r_pend_full) begin
                    r_active    <= r_pending;
                    r_pend_full <= 1'b0;
                end else if (w_xfer) begin
                    // Pending is empty, so a same-cycle transfer bypasses it.
                    r_active <= sampleIn;
                end else begin
                    r_under <= 1'b1;
                end
            end else if (w_xfer) begin
                r_pending   <= sampleIn;
                r_pend_full <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Modulator loop
    // ------------------------------------------------------------------
    // The second integrator consumes the freshly updated first integrator,
    // giving a noise transfer function of (1 - z^-1)^2 with both loop poles
    // at the origin.
    assign w_fb       = r_bit ? C_FS : -C_FS;
    assign w_sum1     = C_EW'(r_acc1) + C_EW'(r_active) - w_fb;
    assign w_acc1_nxt = sat(w_sum1);
    assign w_sum2     = C_EW'(r_acc2) + C_EW'(w_acc1_nxt) - w_fb + w_dith;
    assign w_acc2_nxt = sat(w_sum2);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_acc1 <= '0;
            r_acc2 <= '0;
            r_bit  <= 1'b0;
        end else begin
            r_acc1 <= w_acc1_nxt;
            r_acc2 <= w_acc2_nxt;
            r_bit  <= ~w_acc2_nxt[C_AW-1];
        end
    end

    assign bitOut      = r_bit;
    assign frameStrobe = r_strobe;
    assign underrun    = r_under;

endmodule : dsm_bitstream_gen
`default_nettype wire

// File: tb/tb_dsm_bitstream_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsm_bitstream_gen
// Description : Self-checking bench for dsm_bitstream_gen. A behavioural
//               model (integer arithmetic, a queue for the pending buffer)
//               predicts every output each cycle; density windows, handshake
//               timing and reset behaviour are checked against fixed values.
// Options     : DSM_DITHER_EN - model includes the dither LFSR.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dsm_bitstream_gen;

    localparam int DATA_W   = 12;
    localparam int OSR_LOG2 = 6;
    localparam int FRAME    = 64;
    localparam int FS       = 2048;
    localparam int ACC_LIM  = 32767;

    logic              clk = 1'b0;
    logic              rstN = 1'b1;
    logic [DATA_W-1:0] sampleIn = '0;
    logic              sampleValid = 1'b0;
    logic              sampleReady;
    logic              bitOut;
    logic              frameStrobe;
    logic              underrun;

    dsm_bitstream_gen #(
        .DATA_W      (DATA_W),
        .OSR_LOG2    (OSR_LOG2)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .sampleIn    (sampleIn),
        .sampleValid (sampleValid),
        .sampleReady (sampleReady),
        .bitOut      (bitOut),
        .frameStrobe (frameStrobe),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: observed %0d, required %0d", tag, got, exp);
    endtask

    // Nearest acceptable value: equals v when v lies within [lo, hi].
    function automatic int in_range(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int m_cnt, m_active, m_acc1, m_acc2;
    bit m_bit, m_strobe, m_under;
    int m_pend_q[$];
`ifdef DSM_DITHER_EN
    int m_lfsr;
`endif

    function automatic int clamp(input int v);
        return (v > ACC_LIM) ? ACC_LIM : ((v < -ACC_LIM) ? -ACC_LIM : v);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_active = 0; m_acc1 = 0; m_acc2 = 0;
        m_bit = 1'b0; m_strobe = 1'b0; m_under = 1'b0;
        m_pend_q.delete();
`ifdef DSM_DITHER_EN
        m_lfsr = 16'hACE1;
`endif
    endtask

    task automatic model_step(input bit valid, input int data);
        int  fb, d, a1, a2, nxt_active;
        bit  take;
        fb = m_bit ? FS : -FS;
        d  = 0;
`ifdef DSM_DITHER_EN
        d = (m_lfsr & 1) ? 1 : -1;
        m_lfsr = ((m_lfsr >> 1) |
                  (((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15)) & 32'hFFFF;
`endif
        a1 = clamp(m_acc1 + m_active - fb);
        a2 = clamp(m_acc2 + a1 - fb + d);
        take = valid && (m_pend_q.size() == 0);
        nxt_active = m_active;
        m_strobe = 1'b0;
        m_under  = 1'b0;
        if (m_cnt == FRAME - 1) begin
            m_strobe = 1'b1;
            if (m_pend_q.size() > 0) nxt_active = m_pend_q.pop_front();
            else if (take)           nxt_active = data;
            else                     m_under = 1'b1;
        end else if (take) begin
            m_pend_q.push_back(data);
        end
        m_acc1   = a1;
        m_acc2   = a2;
        m_bit    = (a2 >= 0);
        m_active = nxt_active;
        m_cnt    = (m_cnt + 1) % FRAME;
    endtask

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    bit drv_valid = 1'b0;
    int drv_data  = 0;
    bit last_accept;
    int cyc, ones, strobes, unders, first_strobe;

    // Called at a falling edge: drive inputs, advance one clock, compare.
    task automatic step();
        sampleValid = drv_valid;
        sampleIn    = drv_data[DATA_W-1:0];
        last_accept = drv_valid && sampleReady;
        model_step(drv_valid, drv_data);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_val("bitOut", bitOut, m_bit);
        check_val("frameStrobe", frameStrobe, m_strobe);
        check_val("underrun", underrun, m_under);
        check_val("sampleReady", sampleReady, (m_pend_q.size() == 0));
        ones    += bitOut;
        strobes += frameStrobe;
        unders  += underrun;
        if (frameStrobe && first_strobe == 0) first_strobe = cyc;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Called at a falling edge: asynchronous assert, check, release.
    task automatic do_reset(input string tag);
        rstN = 1'b0;
        model_reset();
        #1;
        check_val({tag, "_bitOut"}, bitOut, 0);
        check_val({tag, "_sampleReady"}, sampleReady, 1);
        check_val({tag, "_frameStrobe"}, frameStrobe, 0);
        check_val({tag, "_underrun"}, underrun, 0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        cyc = 0;
        first_strobe = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time 2ms reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_at [3];
        int k;
        bit found;
        bit offer;

        @(negedge clk);
        do_reset("rst");

        // Zero input, valid held.
        drv_valid = 1'b1; drv_data = 0;
        ones = 0; strobes = 0; unders = 0;
        run(FRAME);
`ifdef DSM_DITHER_EN
        ones = 0;
        run(3 * FRAME);
        check_val("zero_mean_ones_3f", ones, in_range(ones, 93, 99));
`else
        for (int f = 2; f <= 4; f++) begin
            ones = 0;
            run(FRAME);
            check_val($sformatf("zero_ones_frame%0d", f), ones, 32);
        end
`endif
        check_val("zero_strobes", strobes, 4);
        check_val("zero_underruns", unders, 0);
        check_val("first_strobe_cycle", first_strobe, 64);

        // +FS/2 and -FS/2 densities over 16 frames.
        drv_data = FS / 2;
        run(2 * FRAME);
        ones = 0;
        run(16 * FRAME);
        check_val("half_pos_ones_16f", ones, in_range(ones, 16 * 47, 16 * 49));
        drv_data = -FS / 2;
        run(3 * FRAME);
        ones = 0;
        run(16 * FRAME);
        check_val("half_neg_ones_16f", ones, in_range(ones, 16 * 15, 16 * 17));

        // Back-to-back samples A, B, C.
        do_reset("rst_abc");
        acc_at = '{-1, -1, -1};
        k = 0;
        drv_valid = 1'b1; drv_data = 100;
        for (int i = 0; i < 200 && k < 3; i++) begin
            step();
            if (last_accept) begin
                acc_at[k] = cyc;
                k++;
                drv_data = (k == 1) ? 200 : 300;
                if (k == 3) drv_valid = 1'b0;
            end
        end
        check_val("accept_A_cycle", acc_at[0], 1);
        check_val("accept_B_cycle", acc_at[1], 65);
        check_val("accept_C_cycle", acc_at[2], 129);
        strobes = 0; unders = 0;
        run(260 - cyc);
        check_val("idle_strobes", strobes, 2);
        check_val("idle_underruns", unders, 1);

        // Full-scale input, then recovery to zero.
        drv_valid = 1'b1; drv_data = FS - 1;
        run(4 * FRAME);
        ones = 0;
        run(4 * FRAME);
        check_val("fullscale_ones_4f", ones, in_range(ones, 129, 256));
        drv_data = 0;
        run(4 * FRAME);
        ones = 0;
        run(4 * FRAME);
        check_val("recovery_ones_4f", ones, in_range(ones, 124, 132));

        // Random samples with randomly starved frames.
        do_reset("rst_rand");
        drv_data = int'($urandom_range(0, 3072)) - 1536;
        for (int f = 0; f < 16; f++) begin
            offer = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < FRAME; c++) begin
                drv_valid = offer && ($urandom_range(0, 1) == 1);
                step();
                if (last_accept) drv_data = int'($urandom_range(0, 3072)) - 1536;
            end
        end

        // Reset mid-frame with a sample pending.
        drv_valid = 1'b1; drv_data = 500;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_cnt == 30 && m_pend_q.size() == 1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check_val("midreset_setup_found", found, 1);
        do_reset("rst_mid");
        for (int i = 0; i < 80 && first_strobe == 0; i++) step();
        check_val("midreset_next_strobe", first_strobe, 64);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dsm_bitstream_gen
`default_nettype wire
